// File: rtl/timestep_scheduler_pkg.sv
// Shared types and constants for the SNN timestep scheduler slice.
package snn_sched_pkg;

  localparam int TIMER_W       = 32;
  localparam int DEF_FIRST_GAP = 4000;
  localparam int DEF_STEP_GAP  = 1004;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    DISPATCH  = 3'd2,
    BUSY      = 3'd3,
    STEP_END  = 3'd4,
    DONE      = 3'd5
  } sched_state_e;

endpackage

// File: rtl/timestep_scheduler_if.sv
// Frame/core handshake bundle between the scheduler and the core array.
// master: the scheduler side; slave: the core array / frame source side.
interface timestep_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int NUM_STEPS = 16
);
  localparam int STEP_W = $clog2(NUM_STEPS);

  logic                 input_buffer_empty;
  logic                 abort;
  logic [NUM_CORES-1:0] core_done;
  logic [NUM_CORES-1:0] core_start;
  logic                 tick;
  logic [STEP_W-1:0]    step_idx;
  logic                 busy;
  logic                 complete;
  logic                 overrun;
  logic [15:0]          ovr_count;

  modport master (
    input  input_buffer_empty, abort, core_done,
    output core_start, tick, step_idx, busy, complete, overrun, ovr_count
  );

  modport slave (
    output input_buffer_empty, abort, core_done,
    input  core_start, tick, step_idx, busy, complete, overrun, ovr_count
  );
endinterface

// File: rtl/timestep_scheduler_step_timer.sv
// Loadable, enable-gated down-counter that holds at zero; zero flags expiry.
module step_timer
  import snn_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q;

  // load has priority over counting; counting stops at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/timestep_scheduler.sv
// Frame-level timestep scheduler: ticks timesteps from an internal timer and
// serialises the cores (shared synapse-memory port) within each timestep.
// Optional: define TS_OVERRUN_CNT_EN to build the saturating overrun counter;
// otherwise ovr_count reads 0.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a non-empty input buffer
// WAIT_TICK | counting down to the next timestep tick
// DISPATCH  | pulsing core_start for core_idx (tick when core_idx==0)
// BUSY      | waiting for core_done[core_idx]
// STEP_END  | last core finished; advance step or finish the frame
// DONE      | one-cycle complete pulse
module timestep_scheduler
  import snn_sched_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NUM_STEPS = 16,
  parameter int FIRST_GAP = DEF_FIRST_GAP,
  parameter int STEP_GAP  = DEF_STEP_GAP
) (
  input  logic                   clk,
  input  logic                   rst,
  timestep_scheduler_if.master   bus
);

  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int STEP_W = $clog2(NUM_STEPS);

  localparam logic [CORE_W-1:0]  LAST_CORE  = CORE_W'(NUM_CORES - 1);
  localparam logic [STEP_W-1:0]  LAST_STEP  = STEP_W'(NUM_STEPS - 1);
  localparam logic [TIMER_W-1:0] FIRST_LOAD = TIMER_W'(FIRST_GAP);
  localparam logic [TIMER_W-1:0] STEP_LOAD  = TIMER_W'(STEP_GAP);

  sched_state_e        state_q, state_d;
  logic [CORE_W-1:0]   core_idx_q, core_idx_d;
  logic [STEP_W-1:0]   step_idx_q, step_idx_d;
  logic                tmr_load, tmr_en, tmr_zero, tmr_zero_q;
  logic [TIMER_W-1:0]  tmr_load_val;
  logic                done_sel;
  logic                ovr_pulse;

  step_timer u_step_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // only the active core's completion bit matters
  assign done_sel = bus.core_done[core_idx_q];

  // FSM state, sequencing counters and previous-cycle timer flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      core_idx_q <= '0;
      step_idx_q <= '0;
      tmr_zero_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      core_idx_q <= core_idx_d;
      step_idx_q <= step_idx_d;
      tmr_zero_q <= tmr_zero;
    end
  end

  // next-state, counter updates and timer control
  always_comb begin
    state_d      = state_q;
    core_idx_d   = core_idx_q;
    step_idx_d   = step_idx_q;
    tmr_load     = 1'b0;
    tmr_load_val = STEP_LOAD;
    tmr_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.input_buffer_empty) begin
          state_d      = WAIT_TICK;
          step_idx_d   = '0;
          core_idx_d   = '0;
          tmr_load     = 1'b1;
          tmr_load_val = FIRST_LOAD;
        end
      end
      WAIT_TICK: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_d    = DISPATCH;
          core_idx_d = '0;
          tmr_load   = 1'b1;
        end
      end
      DISPATCH: begin
        tmr_en  = 1'b1;
        state_d = BUSY;
      end
      BUSY: begin
        tmr_en = 1'b1;
        if (done_sel) begin
          if (core_idx_q == LAST_CORE) begin
            state_d = STEP_END;
          end else begin
            core_idx_d = core_idx_q + 1'b1;
            state_d    = DISPATCH;
          end
        end
      end
      STEP_END: begin
        tmr_en = 1'b1;
        if (step_idx_q == LAST_STEP) begin
          state_d = DONE;
        end else begin
          step_idx_d = step_idx_q + 1'b1;
          state_d    = WAIT_TICK;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // abort beats everything, including a same-cycle core completion
    if (bus.abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      core_idx_d = '0;
      step_idx_d = '0;
    end
  end

  // timer expiring before the step's work is finished; WAIT_TICK expiry is normal
  assign ovr_pulse = tmr_zero && !tmr_zero_q &&
                     (state_q inside {DISPATCH, BUSY, STEP_END});

  assign bus.core_start = (state_q == DISPATCH) ? (NUM_CORES'(1) << core_idx_q) : '0;
  assign bus.tick       = (state_q == DISPATCH) && (core_idx_q == '0);
  assign bus.busy       = (state_q != IDLE);
  assign bus.complete   = (state_q == DONE);
  assign bus.step_idx   = step_idx_q;
  assign bus.overrun    = ovr_pulse;

`ifdef TS_OVERRUN_CNT_EN
  logic [15:0] ovr_count_q;

  // saturating overrun tally, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_count_q <= '0;
    end else if (ovr_pulse && (ovr_count_q != 16'hFFFF)) begin
      ovr_count_q <= ovr_count_q + 1'b1;
    end
  end

  assign bus.ovr_count = ovr_count_q;
`else
  assign bus.ovr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_timestep_scheduler.sv
// Randomised frame bench for timestep_scheduler with an event-time reference model.
module tb_timestep_scheduler;

  localparam int NC = 2;
  localparam int NS = 3;
  localparam int FG = 10;
  localparam int SG = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  timestep_scheduler_if #(.NUM_CORES(NC), .NUM_STEPS(NS)) bus ();

  timestep_scheduler #(
    .NUM_CORES (NC),
    .NUM_STEPS (NS),
    .FIRST_GAP (FG),
    .STEP_GAP  (SG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int ovr_total = 0;
  bit noise_en  = 1'b0;

  int lat_tab [NS][NC];
  int lat_q [$];
  int due [NC];
  int active = 0;
  logic [NC-1:0] done_v;

  int obs_tick_c[$], obs_tick_s[$], obs_st_c[$], obs_st_m[$], obs_cmp_c[$], obs_ovr_c[$];
  int exp_tick_c[$], exp_tick_s[$], exp_st_c[$], exp_st_m[$], exp_cmp_c[$], exp_ovr_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // event recorder: outputs sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      if (bus.tick) begin
        obs_tick_c.push_back(cyc);
        obs_tick_s.push_back(int'(bus.step_idx));
      end
      if (bus.core_start != '0) begin
        obs_st_c.push_back(cyc);
        obs_st_m.push_back(int'(bus.core_start));
      end
      if (bus.complete) obs_cmp_c.push_back(cyc);
      if (bus.overrun)  obs_ovr_c.push_back(cyc);
    end
  end

  // core array model: done comes lat cycles after start; optional noise on idle bits
  always @(negedge clk) begin
    done_v = '0;
    if (!rst) begin
      for (int c = 0; c < NC; c++) due[c] = -1;
    end else begin
      for (int c = 0; c < NC; c++) begin
        if (bus.core_start[c]) begin
          active = c;
          if (lat_q.size() > 0) due[c] = cyc + lat_q.pop_front();
          else                  due[c] = cyc + 2;
        end
      end
      for (int c = 0; c < NC; c++) begin
        if (due[c] == cyc) done_v[c] = 1'b1;
        else if (noise_en && (c != active) && ($urandom_range(0, 3) == 0)) done_v[c] = 1'b1;
      end
    end
    bus.core_done = done_v;
  end

  function automatic int exp_ovr_count();
`ifdef TS_OVERRUN_CNT_EN
    return (ovr_total > 65535) ? 65535 : ovr_total;
`else
    return 0;
`endif
  endfunction

  task automatic clear_obs();
    obs_tick_c.delete(); obs_tick_s.delete(); obs_st_c.delete();
    obs_st_m.delete();   obs_cmp_c.delete();  obs_ovr_c.delete();
  endtask

  // expected event cycles for a frame whose buffer goes non-empty in IDLE cycle k0
  task automatic predict(input int k0, output int idle_c, output int n_ovr);
    int t, st, e;
    exp_tick_c.delete(); exp_tick_s.delete(); exp_st_c.delete();
    exp_st_m.delete();   exp_cmp_c.delete();  exp_ovr_c.delete();
    n_ovr  = 0;
    idle_c = 0;
    t = k0 + 2 + FG;
    for (int s = 0; s < NS; s++) begin
      exp_tick_c.push_back(t);
      exp_tick_s.push_back(s);
      st = t;
      e  = t;
      for (int c = 0; c < NC; c++) begin
        exp_st_c.push_back(st);
        exp_st_m.push_back(1 << c);
        e  = st + lat_tab[s][c] + 1;
        st = e;
      end
      if (t + SG <= e) begin
        exp_ovr_c.push_back(t + SG);
        n_ovr++;
      end
      if (s == NS - 1) begin
        exp_cmp_c.push_back(e + 1);
        idle_c = e + 2;
      end else begin
        t = (t + SG + 1 > e + 2) ? (t + SG + 1) : (e + 2);
      end
    end
  endtask

  task automatic compare_frame(input string tag);
    check_eq({tag, ":n_tick"}, obs_tick_c.size(), exp_tick_c.size());
    for (int i = 0; i < exp_tick_c.size() && i < obs_tick_c.size(); i++) begin
      check_eq({tag, ":tick_cyc"}, obs_tick_c[i], exp_tick_c[i]);
      check_eq({tag, ":tick_step"}, obs_tick_s[i], exp_tick_s[i]);
    end
    check_eq({tag, ":n_start"}, obs_st_c.size(), exp_st_c.size());
    for (int i = 0; i < exp_st_c.size() && i < obs_st_c.size(); i++) begin
      check_eq({tag, ":start_cyc"}, obs_st_c[i], exp_st_c[i]);
      check_eq({tag, ":start_mask"}, obs_st_m[i], exp_st_m[i]);
    end
    check_eq({tag, ":n_complete"}, obs_cmp_c.size(), exp_cmp_c.size());
    for (int i = 0; i < exp_cmp_c.size() && i < obs_cmp_c.size(); i++)
      check_eq({tag, ":complete_cyc"}, obs_cmp_c[i], exp_cmp_c[i]);
    check_eq({tag, ":n_overrun"}, obs_ovr_c.size(), exp_ovr_c.size());
    for (int i = 0; i < exp_ovr_c.size() && i < obs_ovr_c.size(); i++)
      check_eq({tag, ":overrun_cyc"}, obs_ovr_c[i], exp_ovr_c[i]);
  endtask

  // called at a negedge with the DUT in IDLE; returns at the predicted IDLE cycle
  task automatic run_frame(input string tag, input bit b2b);
    int k0, idle_c, nov;
    k0 = cyc;
    predict(k0, idle_c, nov);
    lat_q.delete();
    for (int s = 0; s < NS; s++)
      for (int c = 0; c < NC; c++) lat_q.push_back(lat_tab[s][c]);
    clear_obs();
    bus.input_buffer_empty = 1'b0;
    while (cyc < idle_c) begin
      @(negedge clk);
      if (cyc < idle_c) bus.input_buffer_empty = 1'($urandom_range(0, 1));
    end
    bus.input_buffer_empty = b2b ? 1'b0 : 1'b1;
    ovr_total += nov;
    compare_frame(tag);
    check_eq({tag, ":ovr_count"}, bus.ovr_count, exp_ovr_count());
    check_eq({tag, ":busy_in_idle"}, bus.busy, 0);
  endtask

  task automatic fill_lat(input int v);
    for (int s = 0; s < NS; s++)
      for (int c = 0; c < NC; c++) lat_tab[s][c] = v;
  endtask

  task automatic abort_test();
    int n, k;
    lat_q.delete();
    clear_obs();
    bus.input_buffer_empty = 1'b0;
    @(negedge clk);
    bus.input_buffer_empty = 1'b1;
    n = 0;
    while (!(bus.tick && (bus.step_idx == 1)) && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    check_eq("abort:reached_step1", (n < 400), 1);
    @(negedge clk);
    check_eq("abort:busy_before", bus.busy, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_eq("abort:busy_after", bus.busy, 0);
    check_eq("abort:core_start_after", bus.core_start, 0);
    obs_cmp_c.delete();
    repeat (40) @(negedge clk);
    check_eq("abort:no_complete", obs_cmp_c.size(), 0);
    check_eq("abort:still_idle", bus.busy, 0);
    // abort while IDLE must not block the restart
    clear_obs();
    k = cyc;
    bus.abort = 1'b1;
    bus.input_buffer_empty = 1'b0;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.input_buffer_empty = 1'b1;
    repeat (FG + 4) @(negedge clk);
    check_eq("restart:n_tick", obs_tick_c.size(), 1);
    if (obs_tick_c.size() > 0) begin
      check_eq("restart:tick_cyc", obs_tick_c[0], k + 2 + FG);
      check_eq("restart:tick_step", obs_tick_s[0], 0);
    end
    n = 0;
    while ((obs_cmp_c.size() == 0) && (n < 500)) begin
      @(negedge clk);
      n++;
    end
    check_eq("restart:complete", obs_cmp_c.size(), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_test();
    int n;
    lat_q.delete();
    bus.input_buffer_empty = 1'b0;
    @(negedge clk);
    bus.input_buffer_empty = 1'b1;
    n = 0;
    while ((bus.core_start == '0) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst:in_dispatch", (bus.core_start != '0), 1);
    #1 rst = 1'b0;
    #1;
    check_eq("rst:core_start_async", bus.core_start, 0);
    check_eq("rst:tick_async", bus.tick, 0);
    check_eq("rst:busy_async", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ovr_total = 0;
    repeat (3) @(negedge clk);
    check_eq("rst:idle_after", bus.busy, 0);
    check_eq("rst:step_idx_after", bus.step_idx, 0);
    check_eq("rst:ovr_count_after", bus.ovr_count, 0);
  endtask

  initial begin
    bus.input_buffer_empty = 1'b1;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset:busy", bus.busy, 0);
    check_eq("reset:core_start", bus.core_start, 0);
    check_eq("reset:tick", bus.tick, 0);
    check_eq("reset:complete", bus.complete, 0);
    check_eq("reset:overrun", bus.overrun, 0);
    check_eq("reset:step_idx", bus.step_idx, 0);
    check_eq("reset:ovr_count", bus.ovr_count, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    fill_lat(2);
    run_frame("nominal", 1'b0);
    repeat (3) @(negedge clk);

    fill_lat(2);
    lat_tab[0][1] = 30;
    run_frame("overrun", 1'b0);
    repeat (2) @(negedge clk);

    noise_en = 1'b1;
    for (int f = 0; f < 20; f++) begin
      bit b2b;
      for (int s = 0; s < NS; s++)
        for (int c = 0; c < NC; c++)
          lat_tab[s][c] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 30))
                                                      : int'($urandom_range(1, 6));
      b2b = (f < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_frame("random", b2b);
      if (!b2b) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    noise_en = 1'b0;
    repeat (40) @(negedge clk);

    abort_test();
    reset_test();

    fill_lat(2);
    run_frame("post_reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
